round_controller: RTL and testbench
===================================

ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 SHALL have parameter ARM_CYCLES, default 2: number of cycles timer_reset is held high in ARM.
REQ-002 SHALL have parameter SCORE_MAX, default 8'h99: BCD saturation value of the score.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  player start button, level, synchronous to clk.
REQ-006 SHALL have port eat  input  1  one-cycle score event pulse from game logic.
REQ-007 SHALL have port timer_done  input  1  done flag from the downstream 60 s BCD countdown.
REQ-008 SHALL have port timer_reset  output  1  drives the countdown's reset_countdown; high loads 60 and clears done.
REQ-009 SHALL have port score_bcd  output  8  current score, two BCD digits, [7:4] tens.
REQ-010 SHALL have port high_bcd  output  8  best score, two BCD digits.
REQ-011 SHALL have ports playing and game_over  output  1 each  high in PLAY and OVER respectively.

Function
REQ-012 SHALL implement FSM states IDLE, ARM, PLAY, OVER; encoding 2 bits.
REQ-013 SHALL detect start rising edge (start=1, previous-cycle start=0); only the edge is acted on.
REQ-014 IDLE: timer_reset=1, score held; start edge -> ARM.
REQ-015 ARM: timer_reset=1 for exactly ARM_CYCLES cycles, score_bcd cleared to 8'h00 on entry; then -> PLAY.
REQ-016 PLAY: timer_reset=0; timer_done sampled from the second PLAY cycle on; timer_done=1 -> OVER next cycle.
REQ-017 PLAY: eat=1 increments score_bcd by 1 in BCD (units 9 -> 0 with tens carry), result visible next cycle.
REQ-018 Score SHALL saturate at SCORE_MAX; eat at SCORE_MAX leaves score unchanged.
REQ-019 eat and timer_done in the same PLAY cycle: increment applied, then -> OVER.
REQ-020 eat outside PLAY SHALL be ignored.
REQ-021 OVER: timer_reset=0, score frozen; start edge -> ARM; start held high across OVER entry causes no restart.
REQ-022 start edges in ARM or PLAY SHALL be ignored.

Reset
REQ-023 reset=1 at any clk edge SHALL force IDLE, score_bcd=8'h00, high_bcd=8'h00, start-edge history=1, ARM counter=0.
REQ-024 Outputs during/after reset: timer_reset=1, playing=0, game_over=0.
REQ-025 reset mid-PLAY SHALL abandon the round without updating high_bcd.

Configuration
REQ-026 Macro HIGH_SCORE_EN: when defined, on the PLAY->OVER transition high_bcd <= score_bcd if score_bcd > high_bcd (BCD compare equals binary compare); value survives rounds, cleared only by reset.
REQ-027 Without HIGH_SCORE_EN: no high-score register, high_bcd tied to 8'h00.

Structure
REQ-028 Shared package round_pkg SHALL hold the state enum/constants, BCD digit width, and SCORE_MAX default.
REQ-029 One sub-module bcd_inc2 (2-digit saturating BCD incrementer, combinational) SHALL be instantiated for the score.
REQ-030 Countdown timer is not instantiated here; timer_reset/timer_done connect at top level.

Verification
REQ-031 reset 3 cycles, then start pulse -> ARM for 2 cycles with timer_reset=1, then PLAY, score_bcd=8'h00.
REQ-032 In PLAY, 11 eat pulses -> score_bcd=8'h11; 10th pulse shows 8'h09->8'h10 carry.
REQ-033 Preload to 8'h98 via 98 eats, 3 more eats -> score_bcd=8'h99 held.
REQ-034 eat and timer_done same cycle at score 8'h05 -> score 8'h06, game_over=1 next cycle, further eats ignored.
REQ-035 HIGH_SCORE_EN: round scores 8'h12 then 8'h07 -> high_bcd=8'h12 after both; without macro high_bcd=8'h00.
REQ-036 reset asserted mid-PLAY at score 8'h40 -> next cycle IDLE, score 8'h00, high_bcd 8'h00, timer_reset=1.

Source files
------------

// File: rtl/round_pkg.sv
// Shared types and constants for the round controller and its BCD score incrementer.
package round_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned SCORE_W = 2 * BCD_DIGIT_W;
  localparam logic [SCORE_W-1:0] SCORE_MAX_DEFAULT = 8'h99;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_PLAY = 2'd2,
    ST_OVER = 2'd3
  } round_state_e;

endpackage

// File: rtl/bcd_inc2.sv
// Two-digit BCD incrementer that saturates at max_i (combinational).
module bcd_inc2
  import round_pkg::*;
(
  input  logic [SCORE_W-1:0] value_i,
  input  logic [SCORE_W-1:0] max_i,
  output logic [SCORE_W-1:0] result_o
);

  logic [BCD_DIGIT_W-1:0] tens;
  logic [BCD_DIGIT_W-1:0] units;

  assign tens  = value_i[SCORE_W-1:BCD_DIGIT_W];
  assign units = value_i[BCD_DIGIT_W-1:0];

  always_comb begin
    result_o = value_i;
    // 99 is also held so a max above the BCD range can never wrap to 00
    if ((value_i != max_i) && (value_i != 8'h99)) begin
      if (units == 4'd9) begin
        result_o = {tens + 4'd1, 4'd0};
      end else begin
        result_o = {tens, units + 4'd1};
      end
    end
  end

endmodule

// File: rtl/round_controller.sv
// Game round sequencer: IDLE -> ARM -> PLAY -> OVER with a saturating BCD score.
// Optional best-score register enabled by defining HIGH_SCORE_EN.
module round_controller
  import round_pkg::*;
#(
  parameter int unsigned      ARM_CYCLES = 2,
  parameter logic [SCORE_W-1:0] SCORE_MAX = SCORE_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               eat,
  input  logic               timer_done,
  output logic               timer_reset,
  output logic [SCORE_W-1:0] score_bcd,
  output logic [SCORE_W-1:0] high_bcd,
  output logic               playing,
  output logic               game_over,
  output logic [1:0]         state_dbg
);

  localparam int unsigned ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);

  round_state_e       state_q, state_d;
  logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               start_prev_q, start_prev_d;
  logic               play_first_q, play_first_d;
  logic [SCORE_W-1:0] score_inc;
  logic               start_edge;

  bcd_inc2 u_score_inc (
    .value_i  (score_q),
    .max_i    (SCORE_MAX),
    .result_o (score_inc)
  );

  assign start_edge   = start & ~start_prev_q;
  assign start_prev_d = start;

  always_comb begin
    state_d      = state_q;
    arm_cnt_d    = arm_cnt_q;
    score_d      = score_q;
    play_first_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          state_d   = ST_ARM;
          arm_cnt_d = '0;
          score_d   = '0;
        end
      end
      ST_ARM: begin
        if (arm_cnt_q == ARM_LAST) begin
          state_d      = ST_PLAY;
          play_first_d = 1'b1;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      ST_PLAY: begin
        if (eat) begin
          score_d = score_inc;
        end
        // the countdown still shows the previous round's done on the first PLAY cycle
        if (timer_done && !play_first_q) begin
          state_d = ST_OVER;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      arm_cnt_q    <= '0;
      score_q      <= '0;
      start_prev_q <= 1'b1;
      play_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      arm_cnt_q    <= arm_cnt_d;
      score_q      <= score_d;
      start_prev_q <= start_prev_d;
      play_first_q <= play_first_d;
    end
  end

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q, high_d;

  // score_d is used so an eat on the final PLAY cycle counts toward the best score
  always_comb begin
    high_d = high_q;
    if ((state_q == ST_PLAY) && (state_d == ST_OVER) && (score_d > high_q)) begin
      high_d = score_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      high_q <= '0;
    end else begin
      high_q <= high_d;
    end
  end

  assign high_bcd = high_q;
`else
  assign high_bcd = '0;
`endif

  assign timer_reset = (state_q == ST_IDLE) || (state_q == ST_ARM);
  assign playing     = (state_q == ST_PLAY);
  assign game_over   = (state_q == ST_OVER);
  assign score_bcd   = score_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller: directed round scenarios plus random play
// compared cycle by cycle against a decimal-score reference model.
module tb_round_controller;

  localparam int ARM_N = 2;

  logic       clk;
  logic       reset;
  logic       start;
  logic       eat;
  logic       timer_done;
  logic       timer_reset;
  logic [7:0] score_bcd;
  logic [7:0] high_bcd;
  logic       playing;
  logic       game_over;
  logic [1:0] state_dbg;

  int checks;
  int failures;

  // reference model: phase names, decimal scores
  typedef enum int {M_IDLE, M_ARM, M_PLAY, M_OVER} m_phase_e;
  m_phase_e m_phase;
  int       m_score;
  int       m_high;
  bit       m_prev_start;
  int       m_arm_left;
  int       m_play_age;

  round_controller #(.ARM_CYCLES(ARM_N), .SCORE_MAX(8'h99)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .eat         (eat),
    .timer_done  (timer_done),
    .timer_reset (timer_reset),
    .score_bcd   (score_bcd),
    .high_bcd    (high_bcd),
    .playing     (playing),
    .game_over   (game_over),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit rst_i, input bit st_i, input bit eat_i, input bit done_i);
    bit edge_seen;
    if (rst_i) begin
      m_phase      = M_IDLE;
      m_score      = 0;
      m_high       = 0;
      m_prev_start = 1'b1;
      m_arm_left   = 0;
      return;
    end
    edge_seen = st_i && !m_prev_start;
    case (m_phase)
      M_IDLE, M_OVER: begin
        if (edge_seen) begin
          m_phase    = M_ARM;
          m_arm_left = ARM_N;
          m_score    = 0;
        end
      end
      M_ARM: begin
        m_arm_left--;
        if (m_arm_left == 0) begin
          m_phase    = M_PLAY;
          m_play_age = 0;
        end
      end
      M_PLAY: begin
        if (eat_i && m_score < 99) m_score++;
        if (done_i && m_play_age >= 1) begin
          m_phase = M_OVER;
`ifdef HIGH_SCORE_EN
          if (m_score > m_high) m_high = m_score;
`endif
        end
        m_play_age++;
      end
      default: ;
    endcase
    m_prev_start = st_i;
  endtask

  task automatic check_all();
    check("timer_reset", {7'd0, timer_reset}, {7'd0, (m_phase == M_IDLE) || (m_phase == M_ARM)});
    check("playing",     {7'd0, playing},     {7'd0, m_phase == M_PLAY});
    check("game_over",   {7'd0, game_over},   {7'd0, m_phase == M_OVER});
    check("score_bcd",   score_bcd,           to_bcd(m_score));
    check("high_bcd",    high_bcd,            to_bcd(m_high));
  endtask

  // driver: apply one cycle of inputs, advance model, check outputs after the edge
  task automatic step(input bit rst_i, input bit st_i, input bit eat_i, input bit done_i);
    @(negedge clk);
    reset      = rst_i;
    start      = st_i;
    eat        = eat_i;
    timer_done = done_i;
    @(posedge clk);
    model_update(rst_i, st_i, eat_i, done_i);
    #1;
    check_all();
  endtask

  task automatic begin_round();
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    start      = 1'b0;
    eat        = 1'b0;
    timer_done = 1'b0;

    // reset for 3 cycles
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    check("reset_timer_reset", {7'd0, timer_reset}, 8'd1);
    step(0, 0, 0, 0);

    // start pulse -> two ARM cycles -> PLAY at score 00
    step(0, 1, 0, 0);
    check("arm1_timer_reset", {7'd0, timer_reset}, 8'd1);
    step(0, 0, 0, 0);
    check("arm2_timer_reset", {7'd0, timer_reset}, 8'd1);
    step(0, 0, 0, 0);
    check("play_entry", {7'd0, playing}, 8'd1);
    check("play_score0", score_bcd, 8'h00);

    // 11 eats with decimal carry on the 10th
    for (int i = 1; i <= 11; i++) begin
      step(0, 0, 1, 0);
      if (i == 9)  check("pre_carry", score_bcd, 8'h09);
      if (i == 10) check("carry", score_bcd, 8'h10);
    end
    check("eleven", score_bcd, 8'h11);

    // climb to 98, then saturate at 99
    for (int i = 0; i < 87; i++) step(0, 0, 1, 0);
    check("preload98", score_bcd, 8'h98);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    check("saturate", score_bcd, 8'h99);

    // start edge in PLAY ignored; start held through OVER entry causes no restart
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    check("over_entry", {7'd0, game_over}, 8'd1);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    check("no_restart", {7'd0, game_over}, 8'd1);
    check("frozen", score_bcd, 8'h99);
    step(0, 0, 0, 0);

    // eat with timer_done at score 05, and timer_done ignored on the first PLAY cycle
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("done_first_cycle_ignored", {7'd0, playing}, 8'd1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    check("eat_done_score", score_bcd, 8'h06);
    check("eat_done_over", {7'd0, game_over}, 8'd1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("over_eat_ignored", score_bcd, 8'h06);

    // best score over rounds of 12 then 7
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    begin_round();
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    begin_round();
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    check("round2_score", score_bcd, 8'h07);
`ifdef HIGH_SCORE_EN
    check("high_kept", high_bcd, 8'h12);
`else
    check("high_tied", high_bcd, 8'h00);
`endif

    // reset mid-PLAY at 40 abandons the round
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    begin_round();
    for (int i = 0; i < 40; i++) step(0, 0, 1, 0);
    check("score40", score_bcd, 8'h40);
    step(1, 0, 1, 1);
    check("midplay_reset_score", score_bcd, 8'h00);
    check("midplay_reset_high", high_bcd, 8'h00);
    check("midplay_reset_timer", {7'd0, timer_reset}, 8'd1);
    check("midplay_reset_playing", {7'd0, playing}, 8'd0);

    // random play against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 29) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
